// File: rtl/alu_share_arbiter_if.sv
// Request/response/ALU bundle for alu_share_arbiter.
// slave: arbiter side. master: requesters, shared ALU and observers.
interface alu_share_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic [1:0]       Req_valid;
  logic [1:0]       Req_ready;
  logic [WIDTH-1:0] Req_SrcA0;
  logic [WIDTH-1:0] Req_SrcB0;
  logic [WIDTH-1:0] Req_SrcA1;
  logic [WIDTH-1:0] Req_SrcB1;
  logic [1:0]       Req_Op0;
  logic [1:0]       Req_Op1;
  logic [1:0]       Rsp_valid;
  logic [1:0]       Rsp_ready;
  logic [WIDTH-1:0] Rsp_Result;
  logic             Rsp_Zero;
  logic [WIDTH-1:0] Alu_SrcA;
  logic [WIDTH-1:0] Alu_SrcB;
  logic [1:0]       Alu_Op;
  logic [WIDTH-1:0] Alu_Result;
  logic             Alu_Zero;
  logic             Busy;
  logic [CNT_W-1:0] Op_count;

  modport slave (
    input  Req_valid, Req_SrcA0, Req_SrcB0, Req_SrcA1, Req_SrcB1,
           Req_Op0, Req_Op1, Rsp_ready, Alu_Result, Alu_Zero,
    output Req_ready, Rsp_valid, Rsp_Result, Rsp_Zero,
           Alu_SrcA, Alu_SrcB, Alu_Op, Busy, Op_count
  );

  modport master (
    output Req_valid, Req_SrcA0, Req_SrcB0, Req_SrcA1, Req_SrcB1,
           Req_Op0, Req_Op1, Rsp_ready, Alu_Result, Alu_Zero,
    input  Req_ready, Rsp_valid, Rsp_Result, Rsp_Zero,
           Alu_SrcA, Alu_SrcB, Alu_Op, Busy, Op_count
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter/sequencer in front of a shared 32-bit ALU, one op in flight.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
//
// state | meaning
// IDLE  | grant and accept one request
// EXEC  | registered operands drive the ALU; result latched at cycle end
// RESP  | response held for the owner until Rsp_ready
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic             gnt_id;
  logic             accept;
  logic             rsp_done;
  logic [1:0]       req_ready_c;
  logic [1:0]       rsp_valid_c;
  logic             busy_c;

  logic [WIDTH-1:0] srca_q;
  logic [WIDTH-1:0] srcb_q;
  logic [1:0]       op_q;
  logic             owner_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic [CNT_W-1:0] cnt_q;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic             last_q;
`endif

  always_comb begin
    gnt_id = 1'b0;
    case (bus.Req_valid)
      2'b10:   gnt_id = 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
      2'b11:   gnt_id = 1'b0;
`else
      2'b11:   gnt_id = ~last_q;
`endif
      default: gnt_id = 1'b0;
    endcase
  end

  assign accept   = (state_q == S_IDLE) && bus.Req_valid[gnt_id];
  assign rsp_done = (state_q == S_RESP) && bus.Rsp_ready[owner_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (rsp_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready_c = 2'b00;
    rsp_valid_c = 2'b00;
    busy_c      = (state_q != S_IDLE);
    if (accept) req_ready_c[gnt_id] = 1'b1;
    if (state_q == S_RESP) rsp_valid_c[owner_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      srca_q   <= '0;
      srcb_q   <= '0;
      op_q     <= 2'b00;
      owner_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (accept) begin
        srca_q  <= gnt_id ? bus.Req_SrcA1 : bus.Req_SrcA0;
        srcb_q  <= gnt_id ? bus.Req_SrcB1 : bus.Req_SrcB0;
        op_q    <= gnt_id ? bus.Req_Op1   : bus.Req_Op0;
        owner_q <= gnt_id;
      end
      if (state_q == S_EXEC) begin
        result_q <= bus.Alu_Result;
        zero_q   <= bus.Alu_Zero;
      end
      if (rsp_done) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

`ifndef ALU_ARB_FIXED_PRIO_EN
  // Pointer starts at 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (accept) begin
      last_q <= gnt_id;
    end
  end
`endif

  assign bus.Req_ready  = req_ready_c;
  assign bus.Rsp_valid  = rsp_valid_c;
  assign bus.Busy       = busy_c;
  assign bus.Rsp_Result = result_q;
  assign bus.Rsp_Zero   = zero_q;
  assign bus.Alu_SrcA   = srca_q;
  assign bus.Alu_SrcB   = srcb_q;
  assign bus.Alu_Op     = op_q;
  assign bus.Op_count   = cnt_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: randomized requests against an arbitration/ALU reference.
module tb_alu_share_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_share_arbiter_if #(.WIDTH(32), .CNT_W(4)) bus ();

  alu_share_arbiter #(.WIDTH(32), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Shared ALU model sitting outside the arbiter.
  logic [31:0] alu_r;
  always_comb begin
    alu_r = 32'h0;
    case (bus.Alu_Op)
      2'b00:   alu_r = bus.Alu_SrcA + bus.Alu_SrcB;
      2'b01:   alu_r = bus.Alu_SrcA - bus.Alu_SrcB;
      2'b10:   alu_r = bus.Alu_SrcA & bus.Alu_SrcB;
      default: alu_r = bus.Alu_SrcA | bus.Alu_SrcB;
    endcase
  end
  assign bus.Alu_Result = alu_r;
  assign bus.Alu_Zero   = (alu_r == 32'h0);

  typedef struct {
    int          owner;
    logic [31:0] res;
    logic        zero;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          done_cnt = 0;
  bit          rsp_rand = 1'b0;
  logic [1:0]  rsp_fixed = 2'b11;
  logic [31:0] p_a[2];
  logic [31:0] p_b[2];
  logic [1:0]  p_op[2];
  bit          p_pend[2];
  int          last_w = 1;

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return a | b;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic drive();
    bus.Req_SrcA0 = p_a[0];
    bus.Req_SrcB0 = p_b[0];
    bus.Req_Op0   = p_op[0];
    bus.Req_SrcA1 = p_a[1];
    bus.Req_SrcB1 = p_b[1];
    bus.Req_Op1   = p_op[1];
    bus.Req_valid = {p_pend[1], p_pend[0]};
  endtask

  task automatic post(input int i, input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] op);
    p_a[i]    = a;
    p_b[i]    = b;
    p_op[i]   = op;
    p_pend[i] = 1'b1;
  endtask

  task automatic post_rand(input int i);
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 3) == 0) post(i, a, a, 2'b01);
    else post(i, a, $urandom, 2'($urandom_range(0, 3)));
  endtask

  task automatic gen_random();
    for (int i = 0; i < 2; i++)
      if (!p_pend[i] && $urandom_range(0, 2) != 0) post_rand(i);
    if (!p_pend[0] && !p_pend[1]) post_rand($urandom_range(0, 1));
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 after the accept edge.
  task automatic round();
    int   w;
    exp_t e;
    if (p_pend[0] && p_pend[1]) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      w = 0;
`else
      w = (last_w == 1) ? 0 : 1;
`endif
    end else begin
      w = p_pend[0] ? 0 : 1;
    end
    e.owner = w;
    e.res   = alu_ref(p_a[w], p_b[w], p_op[w]);
    e.zero  = (e.res == 32'h0);
    exp_q.push_back(e);
    drive();
    @(negedge clk);
    chk("grant", {62'h0, bus.Req_ready}, 64'(2'b01 << w));
    @(posedge clk);
    #1;
    p_pend[w] = 1'b0;
    last_w    = w;
    drive();
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL rsp_timeout: %0d responses outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Rsp_ready driver
  initial begin
    bus.Rsp_ready = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      bus.Rsp_ready = rsp_rand ? 2'($urandom_range(0, 3)) : rsp_fixed;
    end
  end

  // Scoreboard monitor: pops on every response handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && (bus.Rsp_valid & bus.Rsp_ready) != 2'b00) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_rsp: Rsp_valid=%b, expected no response", bus.Rsp_valid);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_owner", {62'h0, bus.Rsp_valid}, 64'(2'b01 << e.owner));
          chk("rsp_result", {32'h0, bus.Rsp_Result}, {32'h0, e.res});
          chk("rsp_zero", {63'h0, bus.Rsp_Zero}, {63'h0, e.zero});
          chk("op_count_pre", {60'h0, bus.Op_count}, 64'(done_cnt % 16));
          done_cnt++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      p_a[i] = 32'h0; p_b[i] = 32'h0; p_op[i] = 2'b00; p_pend[i] = 1'b0;
    end
    rst_n = 1'b0;
    drive();
    #3;
    chk("rst_req_ready", {62'h0, bus.Req_ready}, 64'h0);
    chk("rst_rsp_valid", {62'h0, bus.Rsp_valid}, 64'h0);
    chk("rst_result", {32'h0, bus.Rsp_Result}, 64'h0);
    chk("rst_zero", {63'h0, bus.Rsp_Zero}, 64'h0);
    chk("rst_alu_a", {32'h0, bus.Alu_SrcA}, 64'h0);
    chk("rst_alu_b", {32'h0, bus.Alu_SrcB}, 64'h0);
    chk("rst_alu_op", {62'h0, bus.Alu_Op}, 64'h0);
    chk("rst_busy", {63'h0, bus.Busy}, 64'h0);
    chk("rst_op_count", {60'h0, bus.Op_count}, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single request with 2-cycle latency
    post(0, 32'd5, 32'd3, 2'b01);
    round();
    @(negedge clk);
    chk("lat_exec_busy", {63'h0, bus.Busy}, 64'h1);
    chk("lat_exec_rsp", {62'h0, bus.Rsp_valid}, 64'h0);
    @(negedge clk);
    chk("lat_resp_valid", {62'h0, bus.Rsp_valid}, 64'h1);
    #1;
    wait_done();
    chk("single_op_count", {60'h0, bus.Op_count}, 64'h1);

    // zero flag from requester 1
    post(1, 32'h0000_00F0, 32'h0000_000F, 2'b10);
    round();
    wait_done();

    // tie held for 4 operations
    for (int k = 0; k < 4; k++) begin
      if (!p_pend[0]) post_rand(0);
      if (!p_pend[1]) post_rand(1);
      round();
      wait_done();
    end

    // backpressure with the other requester waiting
    rsp_fixed = 2'b00;
    if (!p_pend[0]) post_rand(0);
    if (!p_pend[1]) post_rand(1);
    round();
    e = exp_q[0];
    @(negedge clk);
    chk("bp_exec_rsp", {62'h0, bus.Rsp_valid}, 64'h0);
    @(negedge clk);
    chk("bp_resp_valid", {62'h0, bus.Rsp_valid}, 64'(2'b01 << e.owner));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", {62'h0, bus.Rsp_valid}, 64'(2'b01 << e.owner));
      chk("bp_hold_result", {32'h0, bus.Rsp_Result}, {32'h0, e.res});
      chk("bp_hold_req_ready", {62'h0, bus.Req_ready}, 64'h0);
      chk("bp_hold_busy", {63'h0, bus.Busy}, 64'h1);
    end
    rsp_fixed = 2'b11;
    wait_done();
    chk("bp_idle_busy", {63'h0, bus.Busy}, 64'h0);
    chk("bp_idle_req_ready", {62'h0, bus.Req_ready}, {62'h0, p_pend[1], p_pend[0]});
    if (p_pend[0] || p_pend[1]) begin
      round();
      wait_done();
    end

    // randomized traffic with random response backpressure
    rsp_rand = 1'b1;
    for (int k = 0; k < 30; k++) begin
      gen_random();
      round();
      wait_done();
    end

    // reset during EXEC drops the operation
    rsp_rand  = 1'b0;
    rsp_fixed = 2'b11;
    p_pend[0] = 1'b0;
    p_pend[1] = 1'b0;
    drive();
    post(0, 32'hFFFF_FFFF, 32'h1, 2'b00);
    round();
    exp_q.delete();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {63'h0, bus.Busy}, 64'h0);
    chk("mid_rst_rsp_valid", {62'h0, bus.Rsp_valid}, 64'h0);
    chk("mid_rst_result", {32'h0, bus.Rsp_Result}, 64'h0);
    chk("mid_rst_zero", {63'h0, bus.Rsp_Zero}, 64'h0);
    chk("mid_rst_alu_a", {32'h0, bus.Alu_SrcA}, 64'h0);
    chk("mid_rst_alu_b", {32'h0, bus.Alu_SrcB}, 64'h0);
    chk("mid_rst_alu_op", {62'h0, bus.Alu_Op}, 64'h0);
    chk("mid_rst_op_count", {60'h0, bus.Op_count}, 64'h0);
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    last_w   = 1;
    done_cnt = 0;
    repeat (5) @(negedge clk);
    chk("post_rst_no_rsp", {62'h0, bus.Rsp_valid}, 64'h0);
    chk("post_rst_op_count", {60'h0, bus.Op_count}, 64'h0);
    @(posedge clk);
    #1;

    // 16 completions wrap the 4-bit counter
    rsp_rand = 1'b1;
    for (int k = 0; k < 16; k++) begin
      gen_random();
      round();
      wait_done();
    end
    chk("wrap_op_count", {60'h0, bus.Op_count}, 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
